// File: rtl/l2_lru_request_driver_if.sv
// Request/grant and LRU-drive signal bundle for l2_lru_request_driver.
// slave = the driver, master = requesters plus the LRU-side observer.
interface l2_lru_request_driver_if #(
    parameter int unsigned NUM_SETS = 128,
    parameter int unsigned NUM_WAYS = 8
);
    localparam int unsigned SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
    localparam int unsigned WAY_W = $clog2(NUM_WAYS);

    logic             fill_req;
    logic [SET_W-1:0] fill_req_set;
    logic             fill_req_lock;
    logic             fill_gnt;
    logic             acc_req;
    logic [SET_W-1:0] acc_req_set;
    logic [WAY_W-1:0] acc_req_way;
    logic             acc_gnt;
    logic             lock_cmd_valid;
    logic [SET_W-1:0] lock_cmd_set;
    logic [WAY_W-1:0] lock_cmd_way;
    logic             lock_cmd_value;
    logic             lock_cmd_ready;
    logic             fill_en;
    logic [SET_W-1:0] fill_set;
    logic             lock_en;
    logic             lock_value;
    logic             access_en;
    logic [SET_W-1:0] access_set;
    logic             access_update_en;
    logic [WAY_W-1:0] access_update_way;
    logic             init_done;

    modport master (
        output fill_req, fill_req_set, fill_req_lock,
        output acc_req, acc_req_set, acc_req_way,
        output lock_cmd_valid, lock_cmd_set, lock_cmd_way, lock_cmd_value,
        input  fill_gnt, acc_gnt, lock_cmd_ready,
        input  fill_en, fill_set, lock_en, lock_value,
        input  access_en, access_set, access_update_en, access_update_way,
        input  init_done
    );

    modport slave (
        input  fill_req, fill_req_set, fill_req_lock,
        input  acc_req, acc_req_set, acc_req_way,
        input  lock_cmd_valid, lock_cmd_set, lock_cmd_way, lock_cmd_value,
        output fill_gnt, acc_gnt, lock_cmd_ready,
        output fill_en, fill_set, lock_en, lock_value,
        output access_en, access_set, access_update_en, access_update_way,
        output init_done
    );
endinterface

// File: rtl/l2_lru_request_driver.sv
// Arbitrates fill / hit-update / lock-command requests onto the L2 LRU ports.
// Define L2_LRU_INIT_SWEEP_EN to add the post-reset lock-clear/LRU-define sweep.
module l2_lru_request_driver #(
    parameter int unsigned NUM_SETS    = 128,
    parameter int unsigned NUM_WAYS    = 8,
    parameter int unsigned LOCK_STARVE = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    l2_lru_request_driver_if.slave  bus
);
    localparam int unsigned SET_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
    localparam int unsigned WAY_W    = $clog2(NUM_WAYS);
    localparam int unsigned STARVE_W = $clog2(LOCK_STARVE + 1);

`ifdef L2_LRU_INIT_SWEEP_EN
    localparam logic [1:0] INIT_A = 2'd0;
    localparam logic [1:0] INIT_B = 2'd1;
`endif
    localparam logic [1:0] RUN    = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                init_done_q, init_done_d;
    logic                fill_en_q, fill_en_d;
    logic [SET_W-1:0]    fill_set_q, fill_set_d;
    logic                lock_en_q, lock_en_d;
    logic                lock_value_q, lock_value_d;
    logic                access_en_q, access_en_d;
    logic [SET_W-1:0]    access_set_q, access_set_d;
    logic                access_update_en_q, access_update_en_d;
    logic [WAY_W-1:0]    access_update_way_q, access_update_way_d;
    logic                upd_pend_q, upd_pend_d;
    logic [WAY_W-1:0]    upd_way_q, upd_way_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
`ifdef L2_LRU_INIT_SWEEP_EN
    logic [SET_W-1:0]    set_cnt_q, set_cnt_d;
    logic [WAY_W-1:0]    way_cnt_q, way_cnt_d;
`endif

    logic grant_ok_c, lock_starved_c, fill_gnt_c, acc_gnt_c, lock_gnt_c;

    // Single issue slot: starved lock > fill > access > lock.
    always_comb begin
        grant_ok_c     = (state_q == RUN) && init_done_q;
        lock_starved_c = bus.lock_cmd_valid && (starve_cnt_q == STARVE_W'(LOCK_STARVE));
        fill_gnt_c     = grant_ok_c && bus.fill_req && !lock_starved_c;
        acc_gnt_c      = grant_ok_c && bus.acc_req && !bus.fill_req && !lock_starved_c;
        lock_gnt_c     = grant_ok_c && bus.lock_cmd_valid &&
                         (lock_starved_c || (!bus.fill_req && !bus.acc_req));
    end

    always_comb begin
        state_d             = state_q;
        init_done_d         = init_done_q;
        fill_en_d           = 1'b0;
        fill_set_d          = fill_set_q;
        lock_en_d           = 1'b0;
        lock_value_d        = lock_value_q;
        access_en_d         = 1'b0;
        access_set_d        = access_set_q;
        access_update_en_d  = 1'b0;
        access_update_way_d = access_update_way_q;
        upd_pend_d          = 1'b0;
        upd_way_d           = upd_way_q;
        starve_cnt_d        = starve_cnt_q;
`ifdef L2_LRU_INIT_SWEEP_EN
        set_cnt_d           = set_cnt_q;
        way_cnt_d           = way_cnt_q;
`endif

        // Phase 2 of last cycle's grant; may overlap the next phase 1.
        if (upd_pend_q) begin
            access_update_en_d  = 1'b1;
            access_update_way_d = upd_way_q;
        end

        case (state_q)
`ifdef L2_LRU_INIT_SWEEP_EN
            INIT_A: begin
                access_en_d  = 1'b1;
                lock_en_d    = 1'b1;
                lock_value_d = 1'b0;
                access_set_d = set_cnt_q;
                state_d      = INIT_B;
            end
            INIT_B: begin
                access_update_en_d  = 1'b1;
                access_update_way_d = way_cnt_q;
                way_cnt_d           = way_cnt_q + WAY_W'(1);
                if (way_cnt_q == WAY_W'(NUM_WAYS - 1)) begin
                    set_cnt_d = set_cnt_q + SET_W'(1);
                end
                if ((set_cnt_q == SET_W'(NUM_SETS - 1)) &&
                    (way_cnt_q == WAY_W'(NUM_WAYS - 1))) begin
                    state_d = RUN;
                end else begin
                    state_d = INIT_A;
                end
            end
`endif
            default: begin
                init_done_d = 1'b1;
                if (fill_gnt_c) begin
                    fill_en_d    = 1'b1;
                    fill_set_d   = bus.fill_req_set;
                    lock_en_d    = bus.fill_req_lock;
                    lock_value_d = 1'b1;
                end else if (acc_gnt_c) begin
                    access_en_d  = 1'b1;
                    access_set_d = bus.acc_req_set;
                    upd_pend_d   = 1'b1;
                    upd_way_d    = bus.acc_req_way;
                end else if (lock_gnt_c) begin
                    access_en_d  = 1'b1;
                    access_set_d = bus.lock_cmd_set;
                    lock_en_d    = 1'b1;
                    lock_value_d = bus.lock_cmd_value;
                    upd_pend_d   = 1'b1;
                    upd_way_d    = bus.lock_cmd_way;
                end

                if (!bus.lock_cmd_valid || lock_gnt_c) begin
                    starve_cnt_d = '0;
                end else if (grant_ok_c && (starve_cnt_q != STARVE_W'(LOCK_STARVE))) begin
                    starve_cnt_d = starve_cnt_q + STARVE_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
`ifdef L2_LRU_INIT_SWEEP_EN
            state_q   <= INIT_A;
            set_cnt_q <= '0;
            way_cnt_q <= '0;
`else
            state_q   <= RUN;
`endif
            init_done_q         <= 1'b0;
            fill_en_q           <= 1'b0;
            fill_set_q          <= '0;
            lock_en_q           <= 1'b0;
            lock_value_q        <= 1'b0;
            access_en_q         <= 1'b0;
            access_set_q        <= '0;
            access_update_en_q  <= 1'b0;
            access_update_way_q <= '0;
            upd_pend_q          <= 1'b0;
            upd_way_q           <= '0;
            starve_cnt_q        <= '0;
        end else begin
`ifdef L2_LRU_INIT_SWEEP_EN
            set_cnt_q <= set_cnt_d;
            way_cnt_q <= way_cnt_d;
`endif
            state_q             <= state_d;
            init_done_q         <= init_done_d;
            fill_en_q           <= fill_en_d;
            fill_set_q          <= fill_set_d;
            lock_en_q           <= lock_en_d;
            lock_value_q        <= lock_value_d;
            access_en_q         <= access_en_d;
            access_set_q        <= access_set_d;
            access_update_en_q  <= access_update_en_d;
            access_update_way_q <= access_update_way_d;
            upd_pend_q          <= upd_pend_d;
            upd_way_q           <= upd_way_d;
            starve_cnt_q        <= starve_cnt_d;
        end
    end

    assign bus.fill_gnt          = fill_gnt_c;
    assign bus.acc_gnt           = acc_gnt_c;
    assign bus.lock_cmd_ready    = lock_gnt_c;
    assign bus.fill_en           = fill_en_q;
    assign bus.fill_set          = fill_set_q;
    assign bus.lock_en           = lock_en_q;
    assign bus.lock_value        = lock_value_q;
    assign bus.access_en         = access_en_q;
    assign bus.access_set        = access_set_q;
    assign bus.access_update_en  = access_update_en_q;
    assign bus.access_update_way = access_update_way_q;
    assign bus.init_done         = init_done_q;
endmodule

// File: tb/tb_l2_lru_request_driver.sv
// Directed self-checking bench for l2_lru_request_driver (NUM_SETS=4, NUM_WAYS=8).
// Honours L2_LRU_INIT_SWEEP_EN the same way the design does.
module tb_l2_lru_request_driver;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    l2_lru_request_driver_if #(.NUM_SETS(4), .NUM_WAYS(8)) bus ();

    l2_lru_request_driver #(.NUM_SETS(4), .NUM_WAYS(8), .LOCK_STARVE(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 32'({bus.fill_gnt, bus.acc_gnt, bus.lock_cmd_ready, bus.fill_en,
                      bus.lock_en, bus.lock_value, bus.access_en, bus.access_update_en,
                      bus.init_done, bus.fill_set, bus.access_set, bus.access_update_way}), 0);
    endtask

    task automatic idle();
        bus.fill_req       = 1'b0;
        bus.fill_req_set   = 2'd0;
        bus.fill_req_lock  = 1'b0;
        bus.acc_req        = 1'b0;
        bus.acc_req_set    = 2'd0;
        bus.acc_req_way    = 3'd0;
        bus.lock_cmd_valid = 1'b0;
        bus.lock_cmd_set   = 2'd0;
        bus.lock_cmd_way   = 3'd0;
        bus.lock_cmd_value = 1'b0;
    endtask

`ifdef L2_LRU_INIT_SWEEP_EN
    // Expects sweep cycles 0..n-1 right after reset release; acc_req is held meanwhile.
    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            chk("sweep_no_grant", 32'(bus.acc_gnt), 0);
            chk("sweep_init_done", 32'(bus.init_done), 0);
            if (i % 2 == 0) begin
                chk("sweep_a_en", 32'({bus.access_en, bus.lock_en, bus.lock_value, bus.access_update_en}), 32'b1100);
                chk("sweep_a_set", 32'(bus.access_set), i / 16);
            end else begin
                chk("sweep_b_en", 32'({bus.access_en, bus.lock_en, bus.access_update_en}), 32'b001);
                chk("sweep_b_way", 32'(bus.access_update_way), (i / 2) % 8);
            end
        end
    endtask
`endif

    // Requests must hold their payload until granted.
    logic       pend_fill, pend_acc, pend_lock;
    logic [1:0] pf_set, pa_set, pl_set;
    logic [2:0] pa_way, pl_way;
    logic       pf_lock, pl_val;
    always @(posedge clk) begin
        if (reset && pend_fill && !(bus.fill_req && bus.fill_req_set == pf_set && bus.fill_req_lock == pf_lock)) begin
            failures++;
            $error("FAIL protocol_fill observed=%0d/%0d expected=%0d/%0d", bus.fill_req_set, bus.fill_req_lock, pf_set, pf_lock);
        end
        if (reset && pend_acc && !(bus.acc_req && bus.acc_req_set == pa_set && bus.acc_req_way == pa_way)) begin
            failures++;
            $error("FAIL protocol_acc observed=%0d/%0d expected=%0d/%0d", bus.acc_req_set, bus.acc_req_way, pa_set, pa_way);
        end
        if (reset && pend_lock && !(bus.lock_cmd_valid && bus.lock_cmd_set == pl_set &&
                                    bus.lock_cmd_way == pl_way && bus.lock_cmd_value == pl_val)) begin
            failures++;
            $error("FAIL protocol_lock observed=%0d/%0d expected=%0d/%0d", bus.lock_cmd_set, bus.lock_cmd_way, pl_set, pl_way);
        end
        pend_fill <= reset && bus.fill_req && !bus.fill_gnt;
        pend_acc  <= reset && bus.acc_req && !bus.acc_gnt;
        pend_lock <= reset && bus.lock_cmd_valid && !bus.lock_cmd_ready;
        pf_set    <= bus.fill_req_set;
        pf_lock   <= bus.fill_req_lock;
        pa_set    <= bus.acc_req_set;
        pa_way    <= bus.acc_req_way;
        pl_set    <= bus.lock_cmd_set;
        pl_way    <= bus.lock_cmd_way;
        pl_val    <= bus.lock_cmd_value;
    end

    initial begin
        reset = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        #1 chk_zero("reset_outputs");

        @(negedge clk);
        reset = 1'b1;
        bus.acc_req = 1'b1; bus.acc_req_set = 2'd2; bus.acc_req_way = 3'd5;
`ifdef L2_LRU_INIT_SWEEP_EN
        sweep(40);
        #1 reset = 1'b0;
        #1 chk_zero("mid_sweep_reset");
        @(negedge clk);
        reset = 1'b1;
        sweep(64);
`else
        #1;
        chk("release_no_grant", 32'(bus.acc_gnt), 0);
        chk("release_init_done", 32'(bus.init_done), 0);
`endif
        // First grant cycle N.
        @(negedge clk); #1;
        chk("init_done_high", 32'(bus.init_done), 1);
        chk("first_acc_gnt", 32'(bus.acc_gnt), 1);

        @(negedge clk); bus.acc_req = 1'b0; #1;
        chk("acc_p1_en", 32'({bus.access_en, bus.lock_en, bus.access_update_en, bus.fill_en}), 32'b1000);
        chk("acc_p1_set", 32'(bus.access_set), 2);
        @(negedge clk); #1;
        chk("acc_p2_en", 32'({bus.access_en, bus.access_update_en}), 32'b01);
        chk("acc_p2_way", 32'(bus.access_update_way), 5);
        @(negedge clk); #1;
        chk("acc_idle", 32'({bus.access_en, bus.access_update_en}), 0);

        // Four back-to-back accesses: set k, way k+4.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 4) begin
                bus.acc_req = 1'b1; bus.acc_req_set = 2'(k); bus.acc_req_way = 3'(k + 4);
            end else begin
                bus.acc_req = 1'b0;
            end
            #1;
            if (k < 4) chk("b2b_gnt", 32'(bus.acc_gnt), 1);
            if (k >= 1 && k <= 4) begin
                chk("b2b_p1_en", 32'(bus.access_en), 1);
                chk("b2b_p1_set", 32'(bus.access_set), k - 1);
            end
            if (k == 5) chk("b2b_p1_done", 32'(bus.access_en), 0);
            if (k >= 2) begin
                chk("b2b_p2_en", 32'(bus.access_update_en), 1);
                chk("b2b_p2_way", 32'(bus.access_update_way), k + 2);
            end
        end
        @(negedge clk); #1;
        chk("b2b_p2_done", 32'(bus.access_update_en), 0);

        // Fill beats access.
        @(negedge clk);
        bus.fill_req = 1'b1; bus.fill_req_set = 2'd3; bus.fill_req_lock = 1'b1;
        bus.acc_req = 1'b1;  bus.acc_req_set = 2'd1;  bus.acc_req_way = 3'd2;
        #1;
        chk("fill_vs_acc_gnt", 32'({bus.fill_gnt, bus.acc_gnt}), 32'b10);
        @(negedge clk); bus.fill_req = 1'b0; #1;
        chk("fill_out", 32'({bus.fill_en, bus.lock_en, bus.lock_value, bus.access_en}), 32'b1110);
        chk("fill_set", 32'(bus.fill_set), 3);
        chk("acc_after_fill_gnt", 32'(bus.acc_gnt), 1);
        @(negedge clk); bus.acc_req = 1'b0; #1;
        chk("acc_after_fill_p1", 32'({bus.fill_en, bus.access_en, bus.lock_en}), 32'b010);
        chk("acc_after_fill_set", 32'(bus.access_set), 1);
        @(negedge clk); #1;
        chk("acc_after_fill_p2", 32'({bus.access_update_en, bus.access_update_way}), 32'b1010);

        // Lock starved behind a continuous fill stream.
        @(negedge clk);
        bus.fill_req = 1'b1; bus.fill_req_set = 2'd0; bus.fill_req_lock = 1'b0;
        bus.lock_cmd_valid = 1'b1; bus.lock_cmd_set = 2'd1; bus.lock_cmd_way = 3'd3; bus.lock_cmd_value = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk("starve_refused", 32'({bus.lock_cmd_ready, bus.fill_gnt}), 32'b01);
            if (c > 0) chk("starve_fill_out", 32'({bus.fill_en, bus.lock_en}), 32'b10);
        end
        @(negedge clk); #1;
        chk("starve_lock_wins", 32'({bus.lock_cmd_ready, bus.fill_gnt}), 32'b10);
        @(negedge clk); bus.lock_cmd_valid = 1'b0; #1;
        chk("starve_lock_p1", 32'({bus.access_en, bus.lock_en, bus.lock_value, bus.fill_en}), 32'b1110);
        chk("starve_lock_set", 32'(bus.access_set), 1);
        chk("starve_fill_regnt", 32'(bus.fill_gnt), 1);
        @(negedge clk); bus.fill_req = 1'b0; #1;
        chk("starve_lock_p2", 32'({bus.access_update_en, bus.access_update_way}), 32'b1011);
        chk("starve_fill_after", 32'({bus.fill_en, bus.lock_en, bus.access_en}), 32'b100);

        // Unlock at lowest priority, uncontended.
        @(negedge clk);
        bus.lock_cmd_valid = 1'b1; bus.lock_cmd_set = 2'd2; bus.lock_cmd_way = 3'd6; bus.lock_cmd_value = 1'b0;
        #1;
        chk("unlock_ready", 32'(bus.lock_cmd_ready), 1);
        @(negedge clk); bus.lock_cmd_valid = 1'b0; #1;
        chk("unlock_p1", 32'({bus.access_en, bus.lock_en, bus.lock_value}), 32'b110);
        chk("unlock_set", 32'(bus.access_set), 2);
        @(negedge clk); #1;
        chk("unlock_p2", 32'({bus.access_update_en, bus.access_update_way, bus.lock_en}), 32'b11100);

        // Reset between phase 1 and phase 2 abandons the update.
        @(negedge clk);
        bus.acc_req = 1'b1; bus.acc_req_set = 2'd3; bus.acc_req_way = 3'd1;
        #1 chk("rst_acc_gnt", 32'(bus.acc_gnt), 1);
        @(negedge clk); bus.acc_req = 1'b0; #1;
        chk("rst_acc_p1", 32'(bus.access_en), 1);
        #1 reset = 1'b0;
        #1 chk_zero("mid_access_reset");
        @(negedge clk);
        reset = 1'b1;
`ifdef L2_LRU_INIT_SWEEP_EN
        sweep(64);
`endif
        @(negedge clk); #1;
        chk("rst_update_dropped", 32'(bus.access_update_en), 0);
        chk("rst_init_done", 32'(bus.init_done), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/l2_lru_request_driver.md
Name: l2_lru_request_driver

Overview:
- Initiator side of the L2 LRU/lock interface. Drives the fill, access/update and lock ports of l2_cache_lru from three request sources: the L2 pipeline fill path, the L2 pipeline hit-update path, and a software lock-command channel.
- After reset it runs an init sweep that clears every lock bit and defines every LRU bit.
- In normal operation it arbitrates the three sources onto one LRU issue slot per cycle and sequences the two-phase access/update protocol.

Parameters:
NUM_SETS, 128, sets in the LRU (power of 2, >=1; SET_W = max(1, $clog2(NUM_SETS)))
NUM_WAYS, 8, ways per set (power of 2, >=2; WAY_W = $clog2(NUM_WAYS))
LOCK_STARVE, 15, cycles a pending lock command may be refused before it takes top priority (>=1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
fill_req  input  1  pipeline requests a fill/victim update
fill_req_set  input  SET_W  set for the fill
fill_req_lock  input  1  lock the filled way
fill_gnt  output  1  fill_req accepted this cycle (combinational)
acc_req  input  1  pipeline hit: promote way to MRU
acc_req_set  input  SET_W  hit set
acc_req_way  input  WAY_W  hit way
acc_gnt  output  1  acc_req accepted this cycle (combinational)
lock_cmd_valid  input  1  software lock/unlock command valid
lock_cmd_set  input  SET_W  target set
lock_cmd_way  input  WAY_W  target way
lock_cmd_value  input  1  1 = lock, 0 = unlock
lock_cmd_ready  output  1  command accepted this cycle (combinational)
fill_en  output  1  to LRU
fill_set  output  SET_W  to LRU
lock_en  output  1  to LRU; qualifies the concurrent fill_en or access_en
lock_value  output  1  to LRU
access_en  output  1  to LRU, phase 1
access_set  output  SET_W  to LRU
access_update_en  output  1  to LRU, phase 2
access_update_way  output  WAY_W  to LRU
init_done  output  1  sweep complete; grants permitted

Behaviour:
- Reset is reset, asynchronous, active-low; clock clk. While low, all outputs = 0, the FSM goes to INIT_A, the set/way counters are cleared and the starvation counter is cleared.
- All LRU-side outputs are registered.
- FSM states: INIT_A, INIT_B, RUN.
  - INIT_A drives, next cycle: access_en=1, lock_en=1, lock_value=0, access_set=set_cnt.
  - INIT_B drives, next cycle: access_update_en=1, access_update_way=way_cnt.
  - INIT_B increments way_cnt; on way wrap it increments set_cnt.
  - After the last set/way the FSM goes to RUN and init_done is registered to 1.
  - The sweep takes exactly 2*NUM_SETS*NUM_WAYS cycles.
- During INIT_*, fill_gnt = acc_gnt = lock_cmd_ready = 0.
- RUN issue slot: at most one grant per cycle.
  - Priority order: starved lock > fill > access > lock.
  - A lock is "starved" when starve_cnt == LOCK_STARVE.
- Timing of a grant in cycle N:
  - Fill: fill_en=1, fill_set and lock_en=fill_req_lock, lock_value=1 are driven in cycle N+1.
  - Access: access_en=1 and access_set are driven in N+1; access_update_en=1 and access_update_way (registered acc_req_way) in N+2; lock_en=0.
  - Lock: same timing as access, with lock_en=1 and lock_value=lock_cmd_value in N+1, and lock_cmd_way on the update in N+2.
- Phase-2 update of one grant may coincide with phase-1 of the next grant. Back-to-back accesses therefore sustain 1 per cycle.
- Unused LRU outputs are 0 in any cycle; the set/way/value buses hold their last value.
- starve_cnt:
  - Increments each RUN cycle with lock_cmd_valid=1 and lock_cmd_ready=0.
  - Saturates at LOCK_STARVE.
  - Clears on lock grant or when lock_cmd_valid=0.
- Requesters hold request and payload until granted. Payload change before grant is illegal; the bench asserts on it.
- Reset asserted mid-sweep or mid-access abandons the in-flight phase-2. The sweep restarts from set 0, way 0 after reset release.

Optional Feature:
L2_LRU_INIT_SWEEP_EN
- Defined: behaviour as above.
- Undefined: no INIT states. FSM resets to RUN, init_done = 1 in the first clock after reset release, and grants are allowed from that cycle. The LRU then relies on its own reset for lock bits. Sweep counters are not synthesised.

Test Plan:
- NUM_SETS=4, NUM_WAYS=8, release reset -> 64 cycles of alternating access_en/lock_en/lock_value=0 then access_update_en, covering set 0..3 × way 0..7 in order. init_done rises on cycle 65; no grant before it.
- RUN, acc_req set=2 way=5 granted at N -> access_en=1, access_set=2 at N+1; access_update_en=1, way=5 at N+2.
- Back-to-back acc_req for 4 cycles -> acc_gnt on 4 consecutive cycles, and overlapping phase-1/phase-2 outputs each cycle.
- fill_req and acc_req both high -> fill_gnt=1 and acc_gnt=0. fill_en=1 next cycle; acc granted the cycle after.
- Continuous fill_req plus lock_cmd_valid (set 1, way 3, value 1) -> lock refused 15 cycles, then lock_cmd_ready=1 over fill. Next cycle: access_en=1, lock_en=1, lock_value=1, set=1; then update way=3.
- Assert reset mid-sweep at set 2 -> all outputs 0 immediately. After release the sweep restarts at set 0, way 0.
